seg_scan_driver: RTL and testbench

Time-multiplexed display driver that sits directly downstream of the game top level. It consumes the seven 7-segment patterns the game produces (flash, level, answer, score high/low, timer high/low) plus one spare position, and scans them onto a single shared-segment 8-digit display. Per-digit ghost blanking, frame-coherent input snapshots and per-digit blinking are included, for example a flashing answer digit on loss.

---
 rtl/seg_scan_driver_pkg.sv | 31 +++
 rtl/seg_scan_driver_if.sv | 21 ++
 rtl/seg_scan_driver_scan_prescaler.sv | 64 ++++++
 rtl/seg_scan_driver.sv | 114 +++++++++++
 tb/tb_seg_scan_driver.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_scan_driver_pkg.sv
// Shared types and constants for the multiplexed 8-digit 7-segment scan driver.
package seg_scan_driver_pkg;

    localparam int unsigned NUM_DIGITS = 8;

    typedef enum logic {
        StBlank = 1'b0,
        StOn    = 1'b1
    } scan_state_e;

    typedef logic [6:0] seg_t;

    localparam seg_t       SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Digit positions as wired from the game top level.
    localparam int unsigned FLASH    = 0;
    localparam int unsigned LEVEL    = 1;
    localparam int unsigned ANSWER   = 2;
    localparam int unsigned SCORE_HI = 3;
    localparam int unsigned SCORE_LO = 4;
    localparam int unsigned TIME_HI  = 5;
    localparam int unsigned TIME_LO  = 6;
    localparam int unsigned SPARE    = 7;

    // Active-low one-hot anode select for digit idx.
    function automatic logic [7:0] an_select(input logic [2:0] idx);
        return ~(8'b1 << idx);
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Game-side pattern inputs and display-side drive outputs of the scan driver.
interface seg_scan_driver_if;
    import seg_scan_driver_pkg::*;

    logic [7*NUM_DIGITS-1:0] seg_bus;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic [NUM_DIGITS-1:0]   an;
    seg_t                    seg_out;
    logic                    frame_tick;

    modport master (
        output seg_bus, blink_mask,
        input  an, seg_out, frame_tick
    );

    modport slave (
        input  seg_bus, blink_mask,
        output an, seg_out, frame_tick
    );

endinterface

// File: rtl/seg_scan_driver_scan_prescaler.sv
// Slot counter and digit index for the scan; emits the per-slot and per-frame strobes.
module scan_prescaler #(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       enable,
    output logic [2:0] idx_next,
    output logic       blank_end,
    output logic       slot_end,
    output logic       frame_start
);

    localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
    localparam logic [CntW-1:0] SlotLast  = CntW'(REFRESH_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic            fresh_q, fresh_d;
    logic            run;

    // fresh_q marks a pending frame start after reset or disable; the scan holds at
    // slot 0, cnt 0 for the cycle that start is taken.
    always_comb begin
        run         = enable & ~fresh_q;
        blank_end   = run && (cnt_q == BlankLast);
        slot_end    = run && (cnt_q == SlotLast);
        frame_start = enable && (fresh_q || (slot_end && (idx_q == 3'd7)));
    end

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        fresh_d = 1'b0;
        if (!enable) begin
            cnt_d   = '0;
            idx_d   = '0;
            fresh_d = 1'b1;
        end else if (fresh_q) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (slot_end) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            fresh_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            fresh_q <= fresh_d;
        end
    end

    assign idx_next = idx_d;

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit display driver with ghost blanking, frame-coherent
// snapshots and per-digit blinking.
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 500,
    parameter int unsigned BLINK_FRAMES = 25
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               enable,
    seg_scan_driver_if.slave   disp
);

    localparam int unsigned FcntW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FcntW-1:0] FcntLast = FcntW'(BLINK_FRAMES - 1);

    scan_state_e             state_q, state_d;
    seg_t [NUM_DIGITS-1:0]   snap_q, snap_d;
    logic [NUM_DIGITS-1:0]   dark_q, dark_d;
    logic [FcntW-1:0]        fcnt_q, fcnt_d;
    logic                    phase_q, phase_d;
    logic [7:0]              an_q, an_d;
    seg_t                    seg_q, seg_d;
    logic                    tick_q;

    logic [2:0] idx_next;
    logic       blank_end;
    logic       slot_end;
    logic       frame_start;

    scan_prescaler #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_prescaler (
        .clock       (clock),
        .rst         (rst),
        .enable      (enable),
        .idx_next    (idx_next),
        .blank_end   (blank_end),
        .slot_end    (slot_end),
        .frame_start (frame_start)
    );

    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q <= StBlank;
            snap_q  <= '1;
            dark_q  <= '0;
            fcnt_q  <= '0;
            phase_q <= 1'b0;
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            dark_q  <= dark_d;
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            tick_q  <= frame_start;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = StBlank;
        end else begin
            unique case (state_q)
                StBlank: if (blank_end) state_d = StOn;
                StOn:    if (slot_end)  state_d = StBlank;
            endcase
        end
    end

    // The blink mask is frozen per frame using the phase from before this frame's
    // tick, so a toggle never splits a frame.
    always_comb begin
        snap_d  = snap_q;
        dark_d  = dark_q;
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (frame_start) begin
            snap_d = disp.seg_bus;
            dark_d = phase_q ? disp.blink_mask : '0;
            if (fcnt_q == FcntLast) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // Outputs are decoded from next-state values so the registered drive lines up
    // with the registered state.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        if (state_d == StOn && !dark_d[idx_next]) begin
            an_d  = an_select(idx_next);
            seg_d = snap_d[idx_next];
        end
    end

    assign disp.an         = an_q;
    assign disp.seg_out    = seg_q;
    assign disp.frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: main instance at 4/1/2, glitch instance at 6/1... 6/2/2.
module tb_seg_scan_driver;
    import seg_scan_driver_pkg::*;

    logic clock = 1'b0;
    logic rst;
    logic enable;
    always #5 clock = ~clock;

    seg_scan_driver_if dif_a();
    seg_scan_driver_if dif_b();

    seg_scan_driver #(
        .REFRESH_DIV  (4),
        .BLANK_CYCLES (1),
        .BLINK_FRAMES (2)
    ) dut_a (
        .clock  (clock),
        .rst    (rst),
        .enable (enable),
        .disp   (dif_a.slave)
    );

    seg_scan_driver #(
        .REFRESH_DIV  (6),
        .BLANK_CYCLES (2),
        .BLINK_FRAMES (2)
    ) dut_b (
        .clock  (clock),
        .rst    (rst),
        .enable (enable),
        .disp   (dif_b.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_v;
    logic [55:0] bus_a, bus_b, bus_c;

    function automatic logic [55:0] game_bus(input seg_t flash, level, answer, score_hi,
                                             score_lo, time_hi, time_lo, spare);
        logic [55:0] b;
        b[FLASH*7    +: 7] = flash;
        b[LEVEL*7    +: 7] = level;
        b[ANSWER*7   +: 7] = answer;
        b[SCORE_HI*7 +: 7] = score_hi;
        b[SCORE_LO*7 +: 7] = score_lo;
        b[TIME_HI*7  +: 7] = time_hi;
        b[TIME_LO*7  +: 7] = time_lo;
        b[SPARE*7    +: 7] = spare;
        return b;
    endfunction

    function logic [15:0] obs_a();
        return {dif_a.frame_tick, dif_a.an, dif_a.seg_out};
    endfunction

    // Expected {tick, an, seg} per cycle of a frame for REFRESH_DIV=4, BLANK_CYCLES=1.
    task automatic push_frame(input logic [55:0] bus, input logic [7:0] dark, input int ncyc);
        logic [7:0] an_e;
        for (int p = 0; p < ncyc; p++) begin
            int slot = p / 4;
            an_e = ~(8'b1 << slot);
            if ((p % 4) == 0 || dark[slot])
                exp_q.push_back({p == 0, 8'hFF, 7'h7F});
            else
                exp_q.push_back({p == 0, an_e, bus[slot*7 +: 7]});
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        enable = 1'b1;
        dif_a.seg_bus = bus_a;
        dif_a.blink_mask = '0;
        dif_b.seg_bus = '0;
        dif_b.blink_mask = '0;
        repeat (2) @(negedge clock);
        n_cmp++;
        if (dif_a.an !== 8'hFF) begin
            n_bad++; $display("FAIL reset_an got %h want ff", dif_a.an);
        end
        n_cmp++;
        if (dif_a.seg_out !== 7'h7F) begin
            n_bad++; $display("FAIL reset_seg got %h want 7f", dif_a.seg_out);
        end
        n_cmp++;
        if (dif_a.frame_tick !== 1'b0) begin
            n_bad++; $display("FAIL reset_tick got %b want 0", dif_a.frame_tick);
        end
        rst = 1'b1;
    endtask

    task automatic test_scan();
        push_frame(bus_a, 8'h00, 32);
        push_frame(bus_a, 8'h00, 32);
        for (int p = 0; p < 64; p++) begin
            @(negedge clock);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs_a() !== exp_v) begin
                n_bad++;
                $display("FAIL scan p=%0d got tick/an/seg %h want %h", p, obs_a(), exp_v);
            end
        end
    endtask

    task automatic test_midframe();
        push_frame(bus_a, 8'h00, 32);
        push_frame(bus_b, 8'h00, 32);
        for (int p = 0; p < 64; p++) begin
            @(negedge clock);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs_a() !== exp_v) begin
                n_bad++;
                $display("FAIL midframe p=%0d got tick/an/seg %h want %h", p, obs_a(), exp_v);
            end
            if (p == 20) dif_a.seg_bus = bus_b;
        end
    endtask

    task automatic test_blink();
        logic [7:0] mask = 8'(1 << ANSWER);
        rst = 1'b0;
        dif_a.seg_bus = bus_a;
        dif_a.blink_mask = mask;
        @(negedge clock);
        rst = 1'b1;
        for (int f = 0; f < 6; f++)
            push_frame(bus_a, (f == 2 || f == 3) ? mask : 8'h00, 32);
        for (int p = 0; p < 192; p++) begin
            @(negedge clock);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs_a() !== exp_v) begin
                n_bad++;
                $display("FAIL blink p=%0d got tick/an/seg %h want %h", p, obs_a(), exp_v);
            end
        end
        dif_a.blink_mask = '0;
    endtask

    task automatic test_enable();
        push_frame(bus_a, 8'h00, 22);
        for (int p = 0; p < 22; p++) begin
            @(negedge clock);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs_a() !== exp_v) begin
                n_bad++;
                $display("FAIL enable_pre p=%0d got %h want %h", p, obs_a(), exp_v);
            end
        end
        enable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            n_cmp++;
            if (obs_a() !== {1'b0, 8'hFF, 7'h7F}) begin
                n_bad++;
                $display("FAIL enable_low k=%0d got %h want %h", k, obs_a(), {1'b0, 8'hFF, 7'h7F});
            end
        end
        enable = 1'b1;
        push_frame(bus_a, 8'h00, 32);
        for (int p = 0; p < 32; p++) begin
            @(negedge clock);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs_a() !== exp_v) begin
                n_bad++;
                $display("FAIL enable_resume p=%0d got %h want %h", p, obs_a(), exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        push_frame(bus_a, 8'h00, 10);
        for (int p = 0; p < 10; p++) begin
            @(negedge clock);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs_a() !== exp_v) begin
                n_bad++;
                $display("FAIL rstmid_pre p=%0d got %h want %h", p, obs_a(), exp_v);
            end
        end
        rst = 1'b0;
        dif_a.seg_bus = bus_c;
        @(negedge clock);
        n_cmp++;
        if (obs_a() !== {1'b0, 8'hFF, 7'h7F}) begin
            n_bad++;
            $display("FAIL rstmid_hold got %h want %h", obs_a(), {1'b0, 8'hFF, 7'h7F});
        end
        rst = 1'b1;
        push_frame(bus_c, 8'h00, 32);
        for (int p = 0; p < 32; p++) begin
            @(negedge clock);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs_a() !== exp_v) begin
                n_bad++;
                $display("FAIL rstmid_post p=%0d got %h want %h", p, obs_a(), exp_v);
            end
        end
    endtask

    task automatic test_glitch();
        logic [63:0] r;
        logic [7:0]  prev_an;
        seg_t        prev_seg;
        int          lit = 0;
        bit          found = 1'b0;
        dif_b.blink_mask = '0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clock);
            found = dif_b.frame_tick;
        end
        n_cmp++;
        if (!found) begin
            n_bad++; $display("FAIL glitch_sync got no frame_tick want one within 100 cycles");
        end
        prev_an = dif_b.an;
        prev_seg = dif_b.seg_out;
        for (int p = 1; p <= 96; p++) begin
            r = {$urandom(), $urandom()};
            dif_b.seg_bus = r[55:0];
            @(negedge clock);
            n_cmp++;
            if (!$onehot0(~dif_b.an)) begin
                n_bad++; $display("FAIL glitch_onehot p=%0d got an %h want <=1 low", p, dif_b.an);
            end
            if (prev_an != 8'hFF && dif_b.an != 8'hFF) begin
                n_cmp++;
                if (dif_b.seg_out !== prev_seg) begin
                    n_bad++;
                    $display("FAIL glitch_seg p=%0d got %h want %h", p, dif_b.seg_out, prev_seg);
                end
            end
            n_cmp++;
            if (dif_b.frame_tick !== ((p % 48) == 0)) begin
                n_bad++;
                $display("FAIL glitch_tick p=%0d got %b want %b", p, dif_b.frame_tick, (p % 48) == 0);
            end
            if (dif_b.an != 8'hFF) lit++;
            prev_an = dif_b.an;
            prev_seg = dif_b.seg_out;
        end
        n_cmp++;
        if (lit != 64) begin
            n_bad++; $display("FAIL glitch_lit got %0d lit cycles want 64", lit);
        end
    endtask

    initial begin
        bus_a = game_bus(7'h40, 7'h41, 7'h42, 7'h43, 7'h44, 7'h45, 7'h46, 7'h47);
        bus_b = bus_a;
        bus_b[SCORE_HI*7 +: 7] = 7'h2A;
        bus_c = game_bus(7'h10, 7'h21, 7'h32, 7'h03, 7'h14, 7'h25, 7'h36, 7'h07);
        test_reset();
        test_scan();
        test_midframe();
        test_blink();
        test_enable();
        test_reset_mid();
        test_glitch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
